wb_cmd_master: RTL
==================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the wait cycles before a bus access is abandoned (legal range 2..65535).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have port wb_clk_i, in, 1, system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port wb_rst_i, in, 1, asynchronous active-high reset.
REQ-005 The block SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_sel in 4, cmd_adr in 32, cmd_dat in 32, forming the command channel (valid/ready).
REQ-006 The block SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_dat out 32, rsp_err out 1, forming the response channel (valid/ready).
REQ-007 The block SHALL have Wishbone master ports wbm_cyc_o out 1, wbm_stb_o out 1, wbm_we_o out 1, wbm_sel_o out 4, wbm_adr_o out 32, wbm_dat_o out 32, wbm_dat_i in 32, wbm_ack_i in 1.

Function
REQ-008 The block SHALL implement FSM states IDLE, BUS, RESP; all Wishbone and rsp_* outputs SHALL be registered.
REQ-009 cmd_ready SHALL be 1 only in IDLE; a handshake occurs on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-010 On handshake the block SHALL latch we/sel/adr/dat, enter BUS, and assert wbm_cyc_o=wbm_stb_o=1 in the next cycle with wbm_we_o/sel/adr/dat driven from the latched values.
REQ-011 In BUS, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o SHALL stay stable until cyc/stb deassert.
REQ-012 When wbm_ack_i=1 is sampled in BUS, the block SHALL, at that edge, drop cyc/stb, load rsp_dat with wbm_dat_i for reads (0 for writes), clear rsp_err, enter RESP.
REQ-013 Single-cycle ack: command handshake at edge N, stb high in cycle N+1, ack sampled at edge N+2, rsp_valid=1 in cycle N+2 (minimum latency 2 cycles).
REQ-014 wbm_ack_i SHALL be ignored in IDLE and RESP.
REQ-015 In RESP, rsp_valid SHALL be 1 with rsp_dat/rsp_err stable until rsp_valid=1 and rsp_ready=1 at an edge; then rsp_valid SHALL clear and the FSM SHALL return to IDLE.
REQ-016 No new command SHALL be accepted before the previous response handshake completes (one outstanding access).
REQ-017 wbm_dat_o SHALL be 0 whenever cyc is low or the access is a read.

Reset
REQ-018 While wb_rst_i=1 the FSM SHALL be IDLE and wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_dat, rsp_err and the timeout counter SHALL be 0; cmd_ready SHALL be 1 after reset.
REQ-019 Reset asserted in BUS or RESP SHALL drop cyc/stb immediately (asynchronously) and discard the pending access without a response.

Configuration
REQ-020 With macro WB_CMD_MASTER_TIMEOUT_EN defined, a 16-bit counter SHALL clear on BUS entry, increment each BUS cycle without ack, and when it equals TIMEOUT_CYCLES-1 without ack the block SHALL drop cyc/stb, set rsp_err=1, rsp_dat=0, enter RESP.
REQ-021 If ack and timeout coincide in the same cycle, ack SHALL win (rsp_err=0).
REQ-022 Without WB_CMD_MASTER_TIMEOUT_EN, no counter SHALL exist, BUS SHALL wait indefinitely for ack, and rsp_err SHALL be constant 0.

Verification
REQ-023 Write adr=0x3000_0004, dat=0x0000_00FF, sel=0xF, ack after 3 wait states -> cyc/stb high exactly 4 cycles, signals stable, rsp_valid=1 with rsp_err=0, rsp_dat=0.
REQ-024 Read adr=0x3000_0000, slave acks in first cycle with wbm_dat_i=0xDEADBEEF -> rsp_valid 2 cycles after handshake, rsp_dat=0xDEADBEEF, wbm_we_o=0 throughout.
REQ-025 TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> cyc/stb high 8 cycles then low, rsp_err=1, rsp_dat=0; ack on the 8th cycle instead -> rsp_err=0.
REQ-026 rsp_ready held 0 for 10 cycles after a completed read -> rsp_valid/rsp_dat stable, cmd_ready=0, second cmd_valid not accepted until rsp_ready=1.
REQ-027 wb_rst_i pulsed mid-BUS -> cyc/stb low in the same cycle, no rsp_valid, cmd_ready=1 after release; stray wbm_ack_i in IDLE -> no response generated.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Command/response to Wishbone classic master bridge with one outstanding access.
// Optional bus timeout is enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES must be in 2..65535");
  end

  state_t      state_q;
  logic        cyc_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_dat_q;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  logic        rsp_err_q;
`endif

  // Bus address/data registers are zeroed whenever cyc is low, so a read never drives write data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q <= BUS;
            cyc_q   <= 1'b1;
            we_q    <= cmd_we;
            sel_q   <= cmd_sel;
            adr_q   <= cmd_adr;
            dat_q   <= cmd_we ? cmd_dat : '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            state_q     <= RESP;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= we_q ? '0 : wbm_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (cnt_q == TimeoutLast) begin
            state_q     <= RESP;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
